// File: rtl/ibex_pkg.sv
// Shared types and constants for the register-file write-back controller.
package ibex_pkg;

  localparam int unsigned RegAddrWidth  = 5;
  localparam int unsigned RfWbDataWidth = 32;
  localparam int unsigned RfWbFifoDepth = 2;
  localparam int unsigned RfWbPtrWidth  = $clog2(RfWbFifoDepth);
  localparam int unsigned RfWbCntWidth  = $clog2(RfWbFifoDepth + 1);

  typedef struct packed {
    logic [RegAddrWidth-1:0]  addr;
    logic [RfWbDataWidth-1:0] data;
  } rf_wb_entry_t;

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Small load-return FIFO; each slot carries a live bit that can be cleared in place
// so a stale entry drains without producing a write.
module ibex_rf_wb_fifo
  import ibex_pkg::*;
#(
  parameter type entry_t = rf_wb_entry_t
) (
  input  logic                     clk_int,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  entry_t                   push_entry_i,
  input  logic                     pop_i,
  input  logic [RfWbFifoDepth-1:0] kill_i,
  output entry_t                   entries_o [RfWbFifoDepth],
  output logic [RfWbFifoDepth-1:0] valid_o,
  output logic [RfWbPtrWidth-1:0]  head_o,
  output logic                     empty_o,
  output logic                     full_o
);

  entry_t                   mem_q [RfWbFifoDepth];
  logic [RfWbFifoDepth-1:0] valid_q, valid_d;
  logic [RfWbPtrWidth-1:0]  head_q, tail_q;
  logic [RfWbCntWidth-1:0]  count_q, count_d;

  function automatic logic [RfWbPtrWidth-1:0] next_ptr(input logic [RfWbPtrWidth-1:0] p);
    return (p == RfWbPtrWidth'(RfWbFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    valid_d = valid_q & ~kill_i;
    if (pop_i) valid_d[head_q] = 1'b0;
    if (push_i) valid_d[tail_q] = 1'b1;
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (pop_i) head_q <= next_ptr(head_q);
      if (push_i) tail_q <= next_ptr(tail_q);
    end
  end

  // Payload needs no reset: a slot is only observed through its live bit.
  always_ff @(posedge clk_int) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign entries_o = mem_q;
  assign valid_o   = valid_q;
  assign head_o    = head_q;
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == RfWbCntWidth'(RfWbFifoDepth));

endmodule

// File: rtl/ibex_rf_wb_ctrl.sv
// Register-file write-port arbiter between EX results and load returns, with
// load buffering, stale-load squashing and read-after-write forwarding.
module ibex_rf_wb_ctrl
  import ibex_pkg::*;
#(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                    clk_int,
  input  logic                    rst_ni,
  input  logic                    ex_we_i,
  input  logic [4:0]              ex_waddr_i,
  input  logic [DataWidth-1:0]    ex_wdata_i,
  input  logic                    lsu_valid_i,
  input  logic [4:0]              lsu_waddr_i,
  input  logic [DataWidth-1:0]    lsu_wdata_i,
  output logic                    lsu_ready_o,
  output logic                    we_a_o,
  output logic [4:0]              waddr_a_o,
  output logic [DataWidth-1:0]    wdata_a_o,
  input  logic [4:0]              raddr_a_i,
  input  logic [4:0]              raddr_b_i,
  output logic                    fwd_hit_a_o,
  output logic                    fwd_hit_b_o,
  output logic [DataWidth-1:0]    fwd_data_a_o,
  output logic [DataWidth-1:0]    fwd_data_b_o,
  output logic                    rd_stall_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam logic [RegAddrWidth-1:0] AddrMask = RegAddrWidth'((1 << AddrWidth) - 1);

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic [DataWidth-1:0]    data;
  } wb_entry_t;

  logic [RegAddrWidth-1:0] ex_addr, lsu_addr, ra_addr, rb_addr;
  logic                    ex_wr, lsu_nz, lsu_acc, bypass, push, pop, head_live, head_wr;

  wb_entry_t                fifo_entries [RfWbFifoDepth];
  wb_entry_t                push_entry;
  logic [RfWbFifoDepth-1:0] fifo_valid, kill, live;
  logic [RfWbPtrWidth-1:0]  fifo_head;
  logic                     fifo_empty, fifo_full;

  logic                    infl_valid_q;
  logic [RegAddrWidth-1:0] infl_addr_q;
  logic [DataWidth-1:0]    infl_data_q;

  // In RV32E the address MSB is ignored, so x16 aliases x0 and is dropped.
  assign ex_addr  = ex_waddr_i & AddrMask;
  assign lsu_addr = lsu_waddr_i & AddrMask;
  assign ra_addr  = raddr_a_i & AddrMask;
  assign rb_addr  = raddr_b_i & AddrMask;

  assign ex_wr  = ex_we_i && (ex_addr != '0);
  assign lsu_nz = (lsu_addr != '0);

  // A fresh EX result supersedes any buffered load to the same register.
  always_comb begin
    kill = '0;
    for (int unsigned i = 0; i < RfWbFifoDepth; i++) begin
      kill[i] = ex_wr && fifo_valid[i] && (fifo_entries[i].addr == ex_addr);
    end
  end

  assign live      = fifo_valid & ~kill;
  assign head_live = live[fifo_head];
  assign head_wr   = !ex_wr && head_live;
  // Dead head slots drain without a write.
  assign pop       = !fifo_empty && (head_wr || !head_live);

  assign lsu_ready_o = !fifo_full;
  assign lsu_acc     = lsu_valid_i && lsu_ready_o;
  assign bypass      = !ex_wr && fifo_empty && lsu_acc && lsu_nz;
  assign push        = lsu_acc && lsu_nz && !bypass && !(ex_wr && (lsu_addr == ex_addr));

  assign push_entry = '{addr: lsu_addr, data: lsu_wdata_i};

  ibex_rf_wb_fifo #(
    .entry_t(wb_entry_t)
  ) u_fifo (
    .clk_int     (clk_int),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .kill_i      (kill),
    .entries_o   (fifo_entries),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    we_a_o    = 1'b0;
    waddr_a_o = '0;
    wdata_a_o = '0;
    if (ex_wr) begin
      we_a_o    = 1'b1;
      waddr_a_o = ex_addr;
      wdata_a_o = ex_wdata_i;
    end else if (head_wr) begin
      we_a_o    = 1'b1;
      waddr_a_o = fifo_entries[fifo_head].addr;
      wdata_a_o = fifo_entries[fifo_head].data;
    end else if (bypass) begin
      we_a_o    = 1'b1;
      waddr_a_o = lsu_addr;
      wdata_a_o = lsu_wdata_i;
    end
  end

  // Covers the register file's one-cycle write latency.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_valid_q <= 1'b0;
      infl_addr_q  <= '0;
      infl_data_q  <= '0;
    end else begin
      infl_valid_q <= we_a_o;
      infl_addr_q  <= waddr_a_o;
      infl_data_q  <= wdata_a_o;
    end
  end

  always_comb begin
    fwd_hit_a_o  = 1'b0;
    fwd_data_a_o = WordZeroVal;
    if (ra_addr != '0) begin
      if (we_a_o && (waddr_a_o == ra_addr)) begin
        fwd_hit_a_o  = 1'b1;
        fwd_data_a_o = wdata_a_o;
      end else if (infl_valid_q && (infl_addr_q == ra_addr)) begin
        fwd_hit_a_o  = 1'b1;
        fwd_data_a_o = infl_data_q;
      end
    end
  end

  always_comb begin
    fwd_hit_b_o  = 1'b0;
    fwd_data_b_o = WordZeroVal;
    if (rb_addr != '0) begin
      if (we_a_o && (waddr_a_o == rb_addr)) begin
        fwd_hit_b_o  = 1'b1;
        fwd_data_b_o = wdata_a_o;
      end else if (infl_valid_q && (infl_addr_q == rb_addr)) begin
        fwd_hit_b_o  = 1'b1;
        fwd_data_b_o = infl_data_q;
      end
    end
  end

  // The head being written this cycle is already covered by forwarding.
  always_comb begin
    rd_stall_o = 1'b0;
    for (int unsigned i = 0; i < RfWbFifoDepth; i++) begin
      if (live[i] && !(head_wr && (fifo_head == RfWbPtrWidth'(i)))) begin
        if (((ra_addr != '0) && (ra_addr == fifo_entries[i].addr)) ||
            ((rb_addr != '0) && (rb_addr == fifo_entries[i].addr))) begin
          rd_stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_wb_ctrl.sv
// Self-checking bench: cycle vectors plus a write scoreboard on the register-file port.
module tb_ibex_rf_wb_ctrl;

  localparam logic [31:0] Z = 32'h5A5A_0000;

  logic        clk_int = 1'b0;
  logic        rst_ni;
  logic        ex_we_i, lsu_valid_i;
  logic [4:0]  ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
  logic [31:0] ex_wdata_i, lsu_wdata_i;
  logic        lsu_ready_o, we_a_o, fwd_hit_a_o, fwd_hit_b_o, rd_stall_o;
  logic [4:0]  waddr_a_o;
  logic [31:0] wdata_a_o, fwd_data_a_o, fwd_data_b_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q [$];
  logic [36:0] sb_e;

  always #5 clk_int = ~clk_int;

  ibex_rf_wb_ctrl #(
    .RV32E      (1'b0),
    .DataWidth  (32),
    .WordZeroVal(Z)
  ) dut (
    .clk_int     (clk_int),
    .rst_ni      (rst_ni),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_ready_o (lsu_ready_o),
    .we_a_o      (we_a_o),
    .waddr_a_o   (waddr_a_o),
    .wdata_a_o   (wdata_a_o),
    .raddr_a_i   (raddr_a_i),
    .raddr_b_i   (raddr_b_i),
    .fwd_hit_a_o (fwd_hit_a_o),
    .fwd_hit_b_o (fwd_hit_b_o),
    .fwd_data_a_o(fwd_data_a_o),
    .fwd_data_b_o(fwd_data_b_o),
    .rd_stall_o  (rd_stall_o)
  );

  typedef struct packed {
    logic        ex_we;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  ea;   // expected write address, 0 = no write
    logic [31:0] ed;
    logic        erdy;
    logic [31:0] eda;  // expected forward data, Z = no hit
    logic [31:0] edb;
    logic        est;
  } vec_t;

  function automatic vec_t row(input logic ex_we, input logic [4:0] ex_a,
                               input logic [31:0] ex_d, input logic lv, input logic [4:0] la,
                               input logic [31:0] ld, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] ea, input logic [31:0] ed, input logic erdy,
                               input logic [31:0] eda, input logic [31:0] edb, input logic est);
    vec_t v;
    v = '{ex_we: ex_we, ex_a: ex_a, ex_d: ex_d, lv: lv, la: la, ld: ld, ra: ra, rb: rb,
          ea: ea, ed: ed, erdy: erdy, eda: eda, edb: edb, est: est};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs(input logic [4:0] ra, input logic [4:0] rb);
    ex_we_i     = 1'b0;
    ex_waddr_i  = '0;
    ex_wdata_i  = '0;
    lsu_valid_i = 1'b0;
    lsu_waddr_i = '0;
    lsu_wdata_i = '0;
    raddr_a_i   = ra;
    raddr_b_i   = rb;
  endtask

  // Drives one cycle, queues its expected write, samples at the falling edge.
  task automatic apply(input string tag, input vec_t v);
    ex_we_i     = v.ex_we;
    ex_waddr_i  = v.ex_a;
    ex_wdata_i  = v.ex_d;
    lsu_valid_i = v.lv;
    lsu_waddr_i = v.la;
    lsu_wdata_i = v.ld;
    raddr_a_i   = v.ra;
    raddr_b_i   = v.rb;
    if (v.ea != '0) exp_q.push_back({v.ea, v.ed});
    @(negedge clk_int);
    chk({tag, "_we"}, 32'(we_a_o), 32'(v.ea != '0));
    if (v.ea == '0) begin
      chk({tag, "_waddr_idle"}, 32'(waddr_a_o), 32'd0);
      chk({tag, "_wdata_idle"}, wdata_a_o, 32'd0);
    end
    chk({tag, "_ready"}, 32'(lsu_ready_o), 32'(v.erdy));
    chk({tag, "_hit_a"}, 32'(fwd_hit_a_o), 32'(v.eda != Z));
    chk({tag, "_data_a"}, fwd_data_a_o, v.eda);
    chk({tag, "_hit_b"}, 32'(fwd_hit_b_o), 32'(v.edb != Z));
    chk({tag, "_data_b"}, fwd_data_b_o, v.edb);
    chk({tag, "_stall"}, 32'(rd_stall_o), 32'(v.est));
    @(posedge clk_int);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, 32'(lsu_ready_o), 32'd1);
    chk({tag, "_we"}, 32'(we_a_o), 32'd0);
    chk({tag, "_hit_a"}, 32'(fwd_hit_a_o), 32'd0);
    chk({tag, "_data_a"}, fwd_data_a_o, Z);
    chk({tag, "_hit_b"}, 32'(fwd_hit_b_o), 32'd0);
    chk({tag, "_data_b"}, fwd_data_b_o, Z);
    chk({tag, "_stall"}, 32'(rd_stall_o), 32'd0);
  endtask

  // Every issued write must match the oldest expected write.
  always @(negedge clk_int) begin
    if (we_a_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: actual x%0d=%h required no write", waddr_a_o, wdata_a_o);
      end else begin
        sb_e = exp_q.pop_front();
        chk("wr_addr", 32'(waddr_a_o), 32'(sb_e[36:32]));
        chk("wr_data", wdata_a_o, sb_e[31:0]);
        chk("wr_nonzero", 32'(waddr_a_o != '0), 32'd1);
      end
    end
  end

  vec_t vecs [$];
  vec_t post [$];

  initial begin
    // ex_we ex_a ex_d  lv la ld  ra rb  ea ed  rdy  da db  stall
    vecs.push_back(row(0, 0, 0, 1, 5, 32'hAAAA_0001, 5, 0, 5, 32'hAAAA_0001, 1,
                       32'hAAAA_0001, Z, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 1, 32'hAAAA_0001, 32'hAAAA_0001, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, Z, Z, 0));
    vecs.push_back(row(1, 3, 32'h33, 1, 7, 32'h77, 7, 3, 3, 32'h33, 1, Z, 32'h33, 0));
    vecs.push_back(row(1, 3, 32'h34, 1, 8, 32'h88, 7, 3, 3, 32'h34, 1, Z, 32'h34, 1));
    vecs.push_back(row(1, 3, 32'h35, 0, 0, 0, 8, 3, 3, 32'h35, 0, Z, 32'h35, 1));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 7, 8, 7, 32'h77, 0, 32'h77, Z, 1));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 7, 8, 8, 32'h88, 1, 32'h77, 32'h88, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 8, 3, 0, 0, 1, 32'h88, Z, 0));
    vecs.push_back(row(1, 1, 32'h11, 1, 9, 32'h99, 9, 1, 1, 32'h11, 1, Z, 32'h11, 0));
    vecs.push_back(row(1, 9, 32'h1234, 0, 0, 0, 9, 1, 9, 32'h1234, 1, 32'h1234, 32'h11, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 32'h1234, Z, 0));
    vecs.push_back(row(1, 4, 32'h44, 1, 4, 32'h4444, 4, 0, 4, 32'h44, 1, 32'h44, Z, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1, 32'h44, Z, 0));
    vecs.push_back(row(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 1, Z, Z, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z, Z, 0));
    vecs.push_back(row(0, 0, 0, 1, 0, 32'hBAD, 0, 0, 0, 0, 1, Z, Z, 0));
    vecs.push_back(row(0, 0, 0, 1, 6, 32'h66, 6, 0, 6, 32'h66, 1, 32'h66, Z, 0));
    vecs.push_back(row(1, 0, 32'h1, 1, 10, 32'hA0, 6, 10, 10, 32'hA0, 1, 32'h66, 32'hA0, 0));
    vecs.push_back(row(1, 2, 32'h22, 1, 11, 32'hB1, 10, 2, 2, 32'h22, 1, 32'hA0, 32'h22, 0));
    vecs.push_back(row(1, 2, 32'h23, 1, 12, 32'hC1, 11, 2, 2, 32'h23, 1, Z, 32'h23, 1));
    vecs.push_back(row(1, 2, 32'h24, 0, 0, 0, 12, 11, 2, 32'h24, 0, Z, Z, 1));

    // After reset: buffers start empty, then a tail entry killed by EX drains silently.
    post.push_back(row(0, 0, 0, 0, 0, 0, 11, 12, 0, 0, 1, Z, Z, 0));
    post.push_back(row(0, 0, 0, 0, 0, 0, 11, 12, 0, 0, 1, Z, Z, 0));
    post.push_back(row(1, 2, 32'h1, 1, 13, 32'hD1, 0, 0, 2, 32'h1, 1, Z, Z, 0));
    post.push_back(row(1, 2, 32'h2, 1, 14, 32'hE1, 13, 0, 2, 32'h2, 1, Z, Z, 1));
    post.push_back(row(1, 14, 32'hE2, 0, 0, 0, 14, 13, 14, 32'hE2, 0, 32'hE2, Z, 1));
    post.push_back(row(0, 0, 0, 0, 0, 0, 14, 13, 13, 32'hD1, 0, 32'hE2, 32'hD1, 0));
    post.push_back(row(0, 0, 0, 0, 0, 0, 14, 0, 0, 0, 1, Z, Z, 0));
    post.push_back(row(0, 0, 0, 1, 15, 32'hF1, 15, 0, 15, 32'hF1, 1, 32'hF1, Z, 0));

    rst_ni = 1'b0;
    idle_inputs(5'd5, 5'd0);
    @(negedge clk_int);
    reset_checks("rst0");
    chk("rst0_waddr", 32'(waddr_a_o), 32'd0);
    chk("rst0_wdata", wdata_a_o, 32'd0);
    @(posedge clk_int);
    #1;
    rst_ni = 1'b1;

    foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

    // Two loads buffered; reset mid-operation must discard them.
    idle_inputs(5'd11, 5'd12);
    rst_ni = 1'b0;
    #1;
    reset_checks("rst1_async");
    @(negedge clk_int);
    reset_checks("rst1");
    @(posedge clk_int);
    @(negedge clk_int);
    reset_checks("rst1_hold");
    @(posedge clk_int);
    #1;
    rst_ni = 1'b1;

    foreach (post[i]) apply($sformatf("p%0d", i), post[i]);

    idle_inputs(5'd0, 5'd0);
    @(negedge clk_int);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
